crc_frame_assembler: RTL

Upstream framing stage for the CRC8 checker in the Sigma Delta DAQ receive path. It takes raw bytes from the serial byte receiver and frames them as DATA_LENGTH_BYTES payload bytes followed by one CRC byte. It streams each frame into the CRC8 checker, sequences the checker's reset and arm cycles, and collects the payload into a word. A word is released only after the checker reports a match; errored or stalled frames are dropped and flagged.

---
 rtl/crc_frame_assembler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_assembler.sv
// Frames raw bytes as payload + CRC byte, drives the CRC8 checker and releases the payload on a match.
// Optional build macro CRC_FRAME_STATS_EN enables the saturating o_err_count statistics counter.
module crc_frame_assembler #(
  parameter int DATA_LENGTH       = 32,
  parameter int DATA_LENGTH_BYTES = DATA_LENGTH / 8,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_byte_valid,
  input  logic [7:0]             i_byte,
  output logic                   o_crc_valid,
  output logic                   o_crc_last,
  output logic [7:0]             o_crc_data,
  output logic                   o_crc_reset,
  input  logic                   i_crc_done,
  input  logic                   i_crc_match,
  output logic [DATA_LENGTH-1:0] o_payload,
  output logic                   o_payload_valid,
  input  logic                   i_payload_ready,
  output logic                   o_crc_error,
  output logic                   o_timeout,
  output logic                   o_drop,
  output logic                   o_busy,
  output logic [15:0]            o_err_count
);

  localparam int CNT_W = $clog2(DATA_LENGTH_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_LENGTH_BYTES);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CRC_RST  = 3'd0;
  localparam logic [2:0] ARM      = 3'd1;
  localparam logic [2:0] COLLECT  = 3'd2;
  localparam logic [2:0] WAIT_CRC = 3'd3;
  localparam logic [2:0] DELIVER  = 3'd4;

  logic [2:0]             state_r;
  logic [CNT_W-1:0]       count_r;
  logic [TMR_W-1:0]       timer_r;
  logic [DATA_LENGTH-1:0] payload_r;
  logic                   crc_valid_r;
  logic                   crc_last_r;
  logic [7:0]             crc_data_r;
  logic                   payload_valid_r;
  logic                   crc_error_r;
  logic                   timeout_r;
  logic                   drop_r;
  logic                   timer_run_s;
  logic                   expire_s;

  // Idle-cycle detection and timeout expiry for the current state.
  always_comb begin
    timer_run_s = 1'b0;
    case (state_r)
      COLLECT:  timer_run_s = (count_r != {CNT_W{1'b0}}) && !i_byte_valid;
      WAIT_CRC: timer_run_s = !i_crc_done;
      default:  timer_run_s = 1'b0;
    endcase
    if (timer_run_s && (timer_r == TMR_LIMIT)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Frame sequencing, byte forwarding, payload assembly and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= CRC_RST;
      count_r         <= {CNT_W{1'b0}};
      timer_r         <= {TMR_W{1'b0}};
      payload_r       <= {DATA_LENGTH{1'b0}};
      crc_valid_r     <= 1'b0;
      crc_last_r      <= 1'b0;
      crc_data_r      <= 8'h00;
      payload_valid_r <= 1'b0;
      crc_error_r     <= 1'b0;
      timeout_r       <= 1'b0;
      drop_r          <= 1'b0;
    end else begin
      crc_valid_r <= 1'b0;
      crc_last_r  <= 1'b0;
      crc_error_r <= 1'b0;
      timeout_r   <= 1'b0;
      drop_r      <= i_byte_valid && (state_r != COLLECT);
      // An accepted byte is never idle, so it always wins over a same-cycle expiry.
      timer_r     <= (timer_run_s && !expire_s) ? timer_r + TMR_W'(1) : {TMR_W{1'b0}};
      case (state_r)
        CRC_RST: begin
          count_r <= {CNT_W{1'b0}};
          state_r <= ARM;
        end
        ARM: begin
          state_r <= COLLECT;
        end
        COLLECT: begin
          if (i_byte_valid) begin
            crc_valid_r <= 1'b1;
            crc_data_r  <= i_byte;
            if (count_r == LAST_CNT) begin
              crc_last_r <= 1'b1;
              count_r    <= {CNT_W{1'b0}};
              state_r    <= WAIT_CRC;
            end else begin
              payload_r <= (payload_r << 8) | DATA_LENGTH'(i_byte);
              count_r   <= count_r + CNT_W'(1);
            end
          end else if (expire_s) begin
            timeout_r <= 1'b1;
            count_r   <= {CNT_W{1'b0}};
            state_r   <= CRC_RST;
          end else begin
            state_r <= COLLECT;
          end
        end
        WAIT_CRC: begin
          if (i_crc_done) begin
            if (i_crc_match) begin
              payload_valid_r <= 1'b1;
              state_r         <= DELIVER;
            end else begin
              crc_error_r <= 1'b1;
              state_r     <= CRC_RST;
            end
          end else if (expire_s) begin
            timeout_r <= 1'b1;
            state_r   <= CRC_RST;
          end else begin
            state_r <= WAIT_CRC;
          end
        end
        DELIVER: begin
          if (i_payload_ready) begin
            payload_valid_r <= 1'b0;
            state_r         <= CRC_RST;
          end else begin
            state_r <= DELIVER;
          end
        end
        default: begin
          payload_valid_r <= 1'b0;
          state_r         <= CRC_RST;
        end
      endcase
    end
  end

`ifdef CRC_FRAME_STATS_EN
  logic [15:0] err_count_r;

  // Saturating count of CRC errors and timeouts; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r <= 16'h0000;
    end else if ((crc_error_r || timeout_r) && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign o_err_count = err_count_r;
`else
  assign o_err_count = 16'h0000;
`endif

  assign o_crc_valid     = crc_valid_r;
  assign o_crc_last      = crc_last_r;
  assign o_crc_data      = crc_data_r;
  assign o_crc_reset     = reset | (state_r == CRC_RST);
  assign o_payload       = payload_r;
  assign o_payload_valid = payload_valid_r;
  assign o_crc_error     = crc_error_r;
  assign o_timeout       = timeout_r;
  assign o_drop          = drop_r;
  assign o_busy          = (state_r != COLLECT) || (count_r != {CNT_W{1'b0}});

endmodule
